// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM (port 0 = core, port 1 = debug).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention handling; otherwise port 0 has fixed priority.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      GLOBAL_CLK_IN,
    input  logic                      GLOBAL_RST_N,
    input  logic                      p0_req,
    input  logic                      p0_we,
    input  logic [ADDR_WIDTH-1:0]     p0_addr,
    input  logic [DATA_WIDTH-1:0]     p0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   p0_wstrb,
    output logic                      p0_gnt,
    output logic                      p0_rvalid,
    output logic [DATA_WIDTH-1:0]     p0_rdata,
    input  logic                      p1_req,
    input  logic                      p1_we,
    input  logic [ADDR_WIDTH-1:0]     p1_addr,
    input  logic [DATA_WIDTH-1:0]     p1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   p1_wstrb,
    output logic                      p1_gnt,
    output logic                      p1_rvalid,
    output logic [DATA_WIDTH-1:0]     p1_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-3:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t                  state_reg;
    logic                    resp_owner_reg;

    logic [1:0]              req;
    logic [1:0]              gnt;
    logic                    win;
    logic                    win_we;
    logic                    rd_gnt;
    logic                    we_arr    [2];
    logic [ADDR_WIDTH-1:0]   addr_arr  [2];
    logic [DATA_WIDTH-1:0]   wdata_arr [2];
    logic [STRB_WIDTH-1:0]   wstrb_arr [2];
    logic [1:0]              rvalid_arr;
    logic [DATA_WIDTH-1:0]   rdata_arr [2];

    assign req          = {p1_req, p0_req};
    assign we_arr[0]    = p0_we;
    assign we_arr[1]    = p1_we;
    assign addr_arr[0]  = p0_addr;
    assign addr_arr[1]  = p1_addr;
    assign wdata_arr[0] = p0_wdata;
    assign wdata_arr[1] = p1_wdata;
    assign wstrb_arr[0] = p0_wstrb;
    assign wstrb_arr[1] = p1_wstrb;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic rr_last_reg;

    // On contention the port that did not win the previous contended grant goes next.
    assign win = (&req) ? ~rr_last_reg : ~req[0];

    always_ff @(posedge GLOBAL_CLK_IN or negedge GLOBAL_RST_N) begin
        if (!GLOBAL_RST_N) begin
            rr_last_reg <= 1'b1;
        end else if (&req) begin
            rr_last_reg <= win;
        end
    end
`else
    assign win = ~req[0];
`endif

    assign gnt[0] = req[0] & ~win;
    assign gnt[1] = req[1] &  win;
    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    assign win_we    = we_arr[win];
    assign mem_en    = |gnt;
    assign mem_we    = mem_en & win_we;
    assign rd_gnt    = mem_en & ~win_we;
    assign mem_addr  = mem_en ? addr_arr[win][ADDR_WIDTH-1:2] : '0;
    assign mem_wdata = mem_we ? wdata_arr[win] : '0;
    assign mem_wstrb = mem_we ? wstrb_arr[win] : '0;

    always_ff @(posedge GLOBAL_CLK_IN or negedge GLOBAL_RST_N) begin
        if (!GLOBAL_RST_N) begin
            state_reg      <= IDLE;
            resp_owner_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (rd_gnt) state_reg <= RESP;
                RESP: if (!rd_gnt) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (rd_gnt) begin
                resp_owner_reg <= win;
            end
        end
    end

    // The RAM's registered read data is steered only to the port that owns the response.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign rvalid_arr[gi] = (state_reg == RESP) && (resp_owner_reg == 1'(gi));
            assign rdata_arr[gi]  = rvalid_arr[gi] ? mem_rdata : '0;
        end
    endgenerate

    assign p0_rvalid = rvalid_arr[0];
    assign p1_rvalid = rvalid_arr[1];
    assign p0_rdata  = rdata_arr[0];
    assign p1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte-strobed 1-cycle-latency RAM attached.
module tb_dmem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic [SW-1:0] p0_wstrb = '0, p1_wstrb = '0;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_we;
    logic [AW-3:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;

    logic [DW-1:0] ram [1 << (AW-2)];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .GLOBAL_CLK_IN(clk), .GLOBAL_RST_N(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port RAM: writes commit at the edge, reads return one cycle later.
    initial begin
        for (int i = 0; i < (1 << (AW-2)); i++) ram[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < SW; b++)
                    if (mem_wstrb[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic drive(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
        if (p == 0) begin
            p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
        end else begin
            p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
        end
    endtask

    task automatic idle();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en} !== 5'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got gnt=%b%b rvalid=%b%b mem_en=%b need all 0",
                         i, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en);
            end
            step();
        end
        $display("test_reset: 10 idle cycles checked");
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 12'h010, 32'hFFFFF63C, 4'hF);
        #1;
        total++;
        if ({p0_gnt, p1_gnt, mem_we, mem_addr, mem_wstrb} !== {3'b101, 10'h004, 4'hF}) begin
            bad++;
            $display("FAIL wr_issue got gnt=%b%b we=%b addr=%h strb=%h need 1 0 1 004 f",
                     p0_gnt, p1_gnt, mem_we, mem_addr, mem_wstrb);
        end
        step();
        drive(0, 1'b0, 12'h010, 32'h0, 4'hF);
        total++;
        if (p0_rvalid !== 1'b0) begin
            bad++; $display("FAIL wr_no_resp got p0_rvalid=%b need 0", p0_rvalid);
        end
        #1;
        total++;
        if ({p0_gnt, mem_en, mem_we, mem_wstrb} !== {3'b110, 4'h0}) begin
            bad++;
            $display("FAIL rd_issue got gnt=%b en=%b we=%b strb=%h need 1 1 0 0",
                     p0_gnt, mem_en, mem_we, mem_wstrb);
        end
        step();
        idle();
        total++;
        if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b10, 32'hFFFFF63C}) begin
            bad++;
            $display("FAIL raw_data got rvalid=%b%b rdata=%h need 10 fffff63c",
                     p0_rvalid, p1_rvalid, p0_rdata);
        end
        step();
        total++;
        if (p0_rvalid !== 1'b0) begin
            bad++; $display("FAIL rd_single got p0_rvalid=%b need 0", p0_rvalid);
        end
        $display("test_write_read: p0 wrote and read back @010");
    endtask

    task automatic test_contention();
        logic exp_p0;
        logic [DW-1:0] exp_data;
        drive(0, 1'b1, 12'h000, 32'hA5A50000, 4'hF); step(); idle();
        drive(1, 1'b1, 12'h004, 32'h5A5A0004, 4'hF); step(); idle();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b0, 12'h000, 32'h0, 4'h0);
            drive(1, 1'b0, 12'h004, 32'h0, 4'h0);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_p0 = (i % 2 == 0);
`else
            exp_p0 = 1'b1;
`endif
            #1;
            total++;
            if ({p0_gnt, p1_gnt} !== {exp_p0, ~exp_p0}) begin
                bad++;
                $display("FAIL contend_gnt cyc=%0d got gnt=%b%b need %b%b",
                         i, p0_gnt, p1_gnt, exp_p0, ~exp_p0);
            end
            step();
            exp_data = exp_p0 ? 32'hA5A50000 : 32'h5A5A0004;
            total++;
            if ({p0_rvalid, p1_rvalid} !== {exp_p0, ~exp_p0} ||
                (exp_p0 ? p0_rdata : p1_rdata) !== exp_data ||
                (exp_p0 ? p1_rdata : p0_rdata) !== 32'h0) begin
                bad++;
                $display("FAIL contend_resp cyc=%0d got rvalid=%b%b rdata0=%h rdata1=%h need owner data %h other 0",
                         i, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, exp_data);
            end
            $display("test_contention: cycle %0d winner p%0d", i, exp_p0 ? 0 : 1);
        end
        idle();
        step();
    endtask

    task automatic test_read_then_write();
        drive(1, 1'b0, 12'h010, 32'h0, 4'h0);
        #1;
        total++;
        if ({p0_gnt, p1_gnt, mem_addr} !== {2'b01, 10'h004}) begin
            bad++;
            $display("FAIL p1_rd_issue got gnt=%b%b addr=%h need 01 004", p0_gnt, p1_gnt, mem_addr);
        end
        step();
        idle();
        drive(0, 1'b1, 12'h014, 32'h12345678, 4'hF);
        #1;
        total++;
        if ({p0_gnt, p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== {3'b110, 32'hFFFFF63C, 32'h0}) begin
            bad++;
            $display("FAIL rd_wr_overlap got p0_gnt=%b rvalid1=%b rvalid0=%b rdata1=%h rdata0=%h need 1 1 0 fffff63c 0",
                     p0_gnt, p1_rvalid, p0_rvalid, p1_rdata, p0_rdata);
        end
        step();
        idle();
        total++;
        if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL wr_after_rd got rvalid=%b%b need 00", p0_rvalid, p1_rvalid);
        end
        $display("test_read_then_write: p1 read @010 overlapped by p0 write @014");
    endtask

    task automatic test_byte_write();
        drive(1, 1'b1, 12'h010, 32'h0000AB00, 4'h2);
        step();
        idle();
        drive(1, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        idle();
        total++;
        if ({p1_rvalid, p1_rdata} !== {1'b1, 32'hFFFFAB3C}) begin
            bad++;
            $display("FAIL byte_strobe got rvalid=%b rdata=%h need 1 ffffab3c", p1_rvalid, p1_rdata);
        end
        step();
        $display("test_byte_write: byte lane 1 merged @010");
    endtask

    task automatic test_reset_mid_read();
        drive(0, 1'b0, 12'h010, 32'h0, 4'h0);
        step();
        idle();
        total++;
        if (p0_rvalid !== 1'b1) begin
            bad++; $display("FAIL pre_reset_rvalid got %b need 1", p0_rvalid);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if ({p0_rvalid, p1_rvalid, p0_rdata} !== {2'b00, 32'h0}) begin
            bad++;
            $display("FAIL async_drop got rvalid=%b%b rdata0=%h need 00 0", p0_rvalid, p1_rvalid, p0_rdata);
        end
        step();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
                bad++;
                $display("FAIL stray_rvalid cyc=%0d got %b%b need 00", i, p0_rvalid, p1_rvalid);
            end
        end
        $display("test_reset_mid_read: response dropped by reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_read_then_write();
        test_byte_write();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
